// File: rtl/crypto_rx_decoder.sv
// UART-style receiver with 16x oversampling that decrypts each received word
// (rotate-right then XOR key) and holds it with valid/overrun/frame error flags.
//
// state | meaning
// IDLE  | line idle, waiting for the synchronized line to go low
// START | checking that the start bit is still low at its midpoint
// DATA  | sampling DBITS data bits, LSB first, at each bit centre
// STOP  | sampling the stop bit; high gives a word, low flags a frame error
module crypto_rx_decoder #(
  parameter int               DBITS   = 8,
  parameter int               N       = 9,
  parameter int               M       = 325,
  parameter int               SB_TICK = 16,
  parameter logic [DBITS-1:0] KEY     = 8'hA5,
  parameter int               ROT     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic             rd_ack,
  input  logic             clr_err,
  input  logic             select,
  output logic [DBITS-1:0] plain_out,
  output logic [DBITS-1:0] cipher_out,
  output logic [DBITS-1:0] led_out,
  output logic             rx_valid,
  output logic             overrun,
  output logic             frame_err
);

  localparam int NW = (DBITS > 1) ? $clog2(DBITS) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       s_reg, s_next;
  logic [NW-1:0]    n_reg, n_next;
  logic [DBITS-1:0] b_reg, b_next;
  logic             rx_meta, rx_s;
  logic [N-1:0]     baud_cnt;
  logic             s_tick;
  logic             done, ferr_set, done_d;
  logic [2*DBITS-1:0] cipher_dbl;
  logic [DBITS-1:0] plain_next;
  logic             ovr_set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign s_tick = (baud_cnt == N'(M - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) baud_cnt <= '0;
    else      baud_cnt <= s_tick ? '0 : baud_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    done       = 1'b0;
    ferr_set   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          s_next     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_reg == 4'd7) begin
            s_next = '0;
            if (!rx_s) begin
              state_next = DATA;
              n_next     = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s_reg + 4'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_reg == 4'd15) begin
            s_next = '0;
            b_next = {rx_s, b_reg[DBITS-1:1]};
            if (n_reg == NW'(DBITS - 1)) state_next = STOP;
            else                         n_next = n_reg + 1'b1;
          end else begin
            s_next = s_reg + 4'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_reg == 4'(SB_TICK - 1)) begin
            state_next = IDLE;
            s_next     = '0;
            if (rx_s) begin
              done = 1'b1;
            end else begin
              ferr_set = 1'b1;
              b_next   = '0;
            end
          end else begin
            s_next = s_reg + 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Doubling the word turns rotate-right into a plain part-select.
  assign cipher_dbl = {cipher_out, cipher_out};
  assign plain_next = cipher_dbl[ROT +: DBITS] ^ KEY;
  assign ovr_set    = done_d && rx_valid && !rd_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cipher_out <= '0;
      plain_out  <= '0;
      done_d     <= 1'b0;
      rx_valid   <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      done_d <= done;
      if (done) cipher_out <= b_reg;
      if (done_d) begin
        plain_out <= plain_next;
        rx_valid  <= 1'b1;
      end else if (rd_ack && rx_valid) begin
        rx_valid <= 1'b0;
      end
      overrun   <= ovr_set  | (overrun   & ~clr_err);
      frame_err <= ferr_set | (frame_err & ~clr_err);
    end
  end

  assign led_out = select ? cipher_out : plain_out;

endmodule

// File: tb/tb_crypto_rx_decoder.sv
// Directed bench for crypto_rx_decoder: serial frames at 64 clk/bit (M=4),
// expected words computed by hand from rotr(c,3) ^ 0xA5.
module tb_crypto_rx_decoder;

  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       rst, rx, rd_ack, clr_err, select;
  logic [7:0] plain_out, cipher_out, led_out;
  logic       rx_valid, overrun, frame_err;

  int passed = 0;
  int total  = 0;
  int failed = 0;
  int words  = 0;
  int words_snap;
  logic rv_q = 1'b0;

  crypto_rx_decoder #(.M(4)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd_ack(rd_ack), .clr_err(clr_err),
    .select(select), .plain_out(plain_out), .cipher_out(cipher_out),
    .led_out(led_out), .rx_valid(rx_valid), .overrun(overrun),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rv_q <= rx_valid;
    if (rx_valid && !rv_q) words <= words + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int clks);
    rx = v;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_val, input int stop_clks);
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BIT);
    drive_bit(stop_val, stop_clks);
    drive_bit(1'b1, 2 * BIT);
  endtask

  task automatic wait_cipher(input logic [7:0] v, output logic found);
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk);
      if (cipher_out == v) found = 1'b1;
    end
  endtask

  task automatic pulse_ack();
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    logic       found;
    logic [7:0] d;
    rst = 1'b0; rx = 1'b1; rd_ack = 1'b0; clr_err = 1'b0; select = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_plain", plain_out, 16'h00);
    check("rst_cipher", cipher_out, 16'h00);
    check("rst_valid", rx_valid, 16'h0);
    check("rst_overrun", overrun, 16'h0);
    check("rst_frame_err", frame_err, 16'h0);
    check("rst_led", led_out, 16'h00);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // 0xCC -> 0x3C; valid follows the cipher load by one clock
    fork
      send_frame(8'hCC, 1'b1, BIT);
      begin
        wait_cipher(8'hCC, found);
        check("cc_seen", found, 16'h1);
        check("cc_valid_lat0", rx_valid, 16'h0);
        @(negedge clk);
        check("cc_valid_lat1", rx_valid, 16'h1);
      end
    join
    check("cc_cipher", cipher_out, 16'hCC);
    check("cc_plain", plain_out, 16'h3C);
    select = 1'b1; #1;
    check("cc_led_sel1", led_out, 16'hCC);
    select = 1'b0; #1;
    check("cc_led_sel0", led_out, 16'h3C);
    check("cc_overrun", overrun, 16'h0);
    pulse_ack();
    check("cc_ack_valid", rx_valid, 16'h0);

    send_frame(8'h00, 1'b1, BIT);
    check("z_plain", plain_out, 16'hA5);
    check("z_valid", rx_valid, 16'h1);
    pulse_ack();
    check("z_ack_valid", rx_valid, 16'h0);
    pulse_ack();
    check("idle_ack_valid", rx_valid, 16'h0);
    check("idle_ack_overrun", overrun, 16'h0);

    send_frame(8'hCC, 1'b1, BIT);
    send_frame(8'h00, 1'b1, BIT);
    check("ovr_plain", plain_out, 16'hA5);
    check("ovr_cipher", cipher_out, 16'h00);
    check("ovr_valid", rx_valid, 16'h1);
    check("ovr_flag", overrun, 16'h1);
    pulse_clr();
    check("ovr_cleared", overrun, 16'h0);
    check("ovr_clr_valid", rx_valid, 16'h1);

    // rd_ack on the plain-load edge: load wins, no overrun
    fork
      send_frame(8'h3C, 1'b1, BIT);
      begin
        wait_cipher(8'h3C, found);
        check("same_seen", found, 16'h1);
        pulse_ack();
      end
    join
    check("same_plain", plain_out, 16'h22);
    check("same_valid", rx_valid, 16'h1);
    check("same_overrun", overrun, 16'h0);
    pulse_ack();
    check("same_ack_valid", rx_valid, 16'h0);

    // stop bit low just past its centre
    send_frame(8'h3C, 1'b0, 40);
    check("fe_flag", frame_err, 16'h1);
    check("fe_valid", rx_valid, 16'h0);
    check("fe_cipher", cipher_out, 16'h3C);
    check("fe_plain", plain_out, 16'h22);
    pulse_clr();
    check("fe_cleared", frame_err, 16'h0);

    // start-bit glitch well under half a bit
    words_snap = words;
    drive_bit(1'b0, 12);
    drive_bit(1'b1, 3 * BIT);
    check("gl_cipher", cipher_out, 16'h3C);
    check("gl_plain", plain_out, 16'h22);
    check("gl_valid", rx_valid, 16'h0);
    check("gl_frame_err", frame_err, 16'h0);
    check("gl_words", words - words_snap, 16'h0);

    // reset during bit 4, then a clean 0xCC
    d = 8'hCC;
    words_snap = words;
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive_bit(d[i], BIT);
    drive_bit(d[4], 20);
    rst = 1'b0; #1;
    check("mid_rst_plain", plain_out, 16'h00);
    check("mid_rst_cipher", cipher_out, 16'h00);
    drive_bit(d[4], BIT - 20);
    for (int i = 5; i < 8; i++) drive_bit(d[i], BIT);
    drive_bit(1'b1, 2 * BIT);
    rst = 1'b1;
    drive_bit(1'b1, BIT);
    send_frame(8'hCC, 1'b1, BIT);
    check("rr_plain", plain_out, 16'h3C);
    check("rr_cipher", cipher_out, 16'hCC);
    check("rr_valid", rx_valid, 16'h1);
    check("rr_words", words - words_snap, 16'h1);
    check("rr_frame_err", frame_err, 16'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
